// File: rtl/alu_sequencer_if.sv
// Request, response and ALU command/data signals of the alu_sequencer.
// The slave modport is the sequencer's view; master is the requester/ALU environment.
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [7:0]       req_flags;

    logic [3:0]       alu_com;
    logic [WIDTH-1:0] alu_bus_out;
    logic [WIDTH-1:0] alu_bus_in;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [7:0]       rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, req_flags, rsp_ready, alu_bus_in,
        input  req_ready, alu_com, alu_bus_out, rsp_valid, rsp_y, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_flags, rsp_ready, alu_bus_in,
        output req_ready, alu_com, alu_bus_out, rsp_valid, rsp_y, rsp_flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Walks one request through the ALU command sequence LA,LB,LF,LOP,COMP,OY,OF and returns Y/flags.
// Optional macro ALU_SEQ_SKIPB_EN: INC/DEC (ops 5/6) skip the LB command.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_LA   = 4'd1;
    localparam logic [3:0] S_LB   = 4'd2;
    localparam logic [3:0] S_LF   = 4'd3;
    localparam logic [3:0] S_LOP  = 4'd4;
    localparam logic [3:0] S_COMP = 4'd5;
    localparam logic [3:0] S_OY   = 4'd6;
    localparam logic [3:0] S_OF   = 4'd7;
    localparam logic [3:0] S_RESP = 4'd8;

    localparam logic [3:0] COM_NOP     = 4'd0;
    localparam logic [3:0] COM_LATCHA  = 4'd1;
    localparam logic [3:0] COM_LATCHB  = 4'd2;
    localparam logic [3:0] COM_LATCHF  = 4'd3;
    localparam logic [3:0] COM_LATCHOP = 4'd4;
    localparam logic [3:0] COM_OUTPUTY = 4'd5;
    localparam logic [3:0] COM_OUTPUTF = 4'd6;
    localparam logic [3:0] COM_COMPUTE = 4'd7;

    logic [3:0]       state_reg, state_next;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg, y_reg;
    logic [7:0]       flags_reg, rsp_flags_reg;
    logic             skip_b;

`ifdef ALU_SEQ_SKIPB_EN
    // INC and DEC never read B, so its latch cycle is dropped
    assign skip_b = (op_reg == 4'd5) || (op_reg == 4'd6);
`else
    assign skip_b = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.req_valid) state_next = S_LA;
            S_LA:    state_next = skip_b ? S_LF : S_LB;
            S_LB:    state_next = S_LF;
            S_LF:    state_next = S_LOP;
            S_LOP:   state_next = S_COMP;
            S_COMP:  state_next = S_OY;
            S_OY:    state_next = S_OF;
            S_OF:    state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            flags_reg     <= '0;
            y_reg         <= '0;
            rsp_flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && bus.req_valid) begin
                op_reg    <= bus.req_op;
                a_reg     <= bus.req_a;
                b_reg     <= bus.req_b;
                flags_reg <= bus.req_flags;
            end
            if (state_reg == S_OY) y_reg <= bus.alu_bus_in;
            if (state_reg == S_OF) rsp_flags_reg <= bus.alu_bus_in[7:0];
        end
    end

    // Command and data are pure decodes of state so a reset drops them at once
    always_comb begin
        bus.alu_com     = COM_NOP;
        bus.alu_bus_out = '0;
        case (state_reg)
            S_LA: begin
                bus.alu_com     = COM_LATCHA;
                bus.alu_bus_out = a_reg;
            end
            S_LB: begin
                bus.alu_com     = COM_LATCHB;
                bus.alu_bus_out = b_reg;
            end
            S_LF: begin
                bus.alu_com     = COM_LATCHF;
                bus.alu_bus_out = {{(WIDTH-8){1'b0}}, flags_reg};
            end
            S_LOP: begin
                bus.alu_com     = COM_LATCHOP;
                bus.alu_bus_out = {{(WIDTH-4){1'b0}}, op_reg};
            end
            S_COMP:  bus.alu_com = COM_COMPUTE;
            S_OY:    bus.alu_com = COM_OUTPUTY;
            S_OF:    bus.alu_com = COM_OUTPUTF;
            default: bus.alu_com = COM_NOP;
        endcase
    end

    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.rsp_valid = (state_reg == S_RESP);
    assign bus.rsp_y     = y_reg;
    assign bus.rsp_flags = rsp_flags_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU answers the command stream,
// the driver queues expected responses and a monitor checks trace, latency and results.
module tb_alu_sequencer;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus();
    alu_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  f;
        logic [15:0] y;
        logic [7:0]  fl;
        int          acc;
    } item_t;
    item_t sb[$];

    // Reference ALU: flags bit0 carry/borrow, bit1 zero, bit2 sign
    function automatic logic [23:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [7:0] fi);
        logic [16:0] r;
        r = '0;
        case (op)
            4'd0:  r = {1'b0, a} + {1'b0, b};
            4'd1:  r = {1'b0, a} + {1'b0, b} + {16'd0, fi[0]};
            4'd2:  r = {1'b0, a} - {1'b0, b};
            4'd3:  r = {1'b0, a} - {1'b0, b} - {16'd0, fi[0]};
            4'd4:  r = 17'd0 - {1'b0, a};
            4'd5:  r = {1'b0, a} + 17'd1;
            4'd6:  r = {1'b0, a} - 17'd1;
            4'd7:  r = {1'b0, a & b};
            4'd8:  r = {1'b0, a | b};
            4'd9:  r = {1'b0, a ^ b};
            4'd10: r = {1'b0, ~a};
            4'd11: r = {a, 1'b0};
            4'd12: r = {1'b0, a >> 1};
            4'd13: r = {1'b0, a[15], a[15:1]};
            4'd14: r = {1'b0, a[14:0], a[15]};
            default: r = {1'b0, a[0], a[15:1]};
        endcase
        return {5'd0, r[15], (r[15:0] == 16'd0), r[16], r[15:0]};
    endfunction

    // Behavioural ALU attached to the command port
    logic [15:0] ma = '0, mb = '0, my = '0;
    logic [7:0]  mf = '0, mfl = '0;
    logic [3:0]  mop = '0;
    always @(posedge clk) begin
        case (bus.alu_com)
            4'd1: ma <= bus.alu_bus_out;
            4'd2: mb <= bus.alu_bus_out;
            4'd3: mf <= bus.alu_bus_out[7:0];
            4'd4: mop <= bus.alu_bus_out[3:0];
            4'd7: {mfl, my} <= alu_fn(mop, ma, mb, mf);
            default: ;
        endcase
    end
    assign bus.alu_bus_in = (bus.alu_com == 4'd5) ? my :
                            (bus.alu_com == 4'd6) ? {8'h00, mfl} : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_skip(input logic [3:0] op);
`ifdef ALU_SEQ_SKIPB_EN
        return (op == 4'd5) || (op == 4'd6);
`else
        return (op == 4'd0) && (op == 4'd1);
`endif
    endfunction

    // Monitor: samples 2 time units after the falling edge
    logic [3:0]  trace_c[$];
    logic [15:0] trace_d[$];
    bit          in_resp = 0;
    int          txn = 0;
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            trace_c.delete();
            trace_d.delete();
            in_resp = 0;
        end else begin
            if (bus.alu_com != 4'd0) begin
                trace_c.push_back(bus.alu_com);
                trace_d.push_back(bus.alu_bus_out);
            end
            if (bus.rsp_valid) begin
                chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard, y=0x%0h", bus.rsp_y);
                end else begin
                    item_t cur;
                    logic [3:0]  ec[$];
                    logic [15:0] ed[$];
                    cur = sb[0];
                    if (!in_resp) begin
                        if (is_skip(cur.op)) begin
                            ec = '{4'd1, 4'd3, 4'd4, 4'd7, 4'd5, 4'd6};
                            ed = '{cur.a, {8'd0, cur.f}, {12'd0, cur.op}, 16'd0, 16'd0, 16'd0};
                        end else begin
                            ec = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd5, 4'd6};
                            ed = '{cur.a, cur.b, {8'd0, cur.f}, {12'd0, cur.op}, 16'd0, 16'd0, 16'd0};
                        end
                        chk("latency", cyc - cur.acc + 1, ec.size() + 1);
                        chk("trace_len", trace_c.size(), ec.size());
                        for (int i = 0; i < ec.size() && i < trace_c.size(); i++) begin
                            chk($sformatf("com[%0d]", i), {28'd0, trace_c[i]}, {28'd0, ec[i]});
                            chk($sformatf("bus_out[%0d]", i), {16'd0, trace_d[i]}, {16'd0, ed[i]});
                        end
                        $display("txn %0d: op=%0d a=0x%04h b=0x%04h f=0x%02h -> y=0x%04h fl=0x%02h (exp 0x%04h/0x%02h)",
                                 txn, cur.op, cur.a, cur.b, cur.f, bus.rsp_y, bus.rsp_flags, cur.y, cur.fl);
                        txn++;
                    end
                    chk("rsp_y", {16'd0, bus.rsp_y}, {16'd0, cur.y});
                    chk("rsp_flags", {24'd0, bus.rsp_flags}, {24'd0, cur.fl});
                    in_resp = 1;
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        in_resp = 0;
                        trace_c.delete();
                        trace_d.delete();
                    end
                end
            end
        end
    end

    // Random backpressure when enabled
    bit rand_ready = 0;
    always @(negedge clk) if (rand_ready) bus.rsp_ready = ($urandom_range(0, 2) != 0);

    // Drive a request (called at a falling edge); leaves req_valid high on return
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, output int acc);
        item_t it;
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_flags = f;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, n);
            acc = -1;
            bus.req_valid = 1'b0;
        end else begin
            it.op = op; it.a = a; it.b = b; it.f = f;
            {it.fl, it.y} = alu_fn(op, a, b, f);
            it.acc = cyc + 1;
            acc = it.acc;
            sb.push_back(it);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = 1'b0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc1, acc2, n;
        bus.req_valid = 1'b0;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_flags = '0;
        bus.rsp_ready = 1'b1;

        #1 reset = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_alu_com", {28'd0, bus.alu_com}, 32'd0);
        chk("rst_bus_out", {16'd0, bus.alu_bus_out}, 32'd0);
        chk("rst_rsp_y", {16'd0, bus.rsp_y}, 32'd0);
        chk("rst_rsp_flags", {24'd0, bus.rsp_flags}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(4'd0, 16'h1234, 16'h0001, 8'h00, acc1);   // ADD
        drain();
        send(4'd1, 16'hFFFF, 16'h0000, 8'h01, acc1);   // ADC
        drain();

        // Backpressure with an ignored request pulse
        bus.rsp_ready = 1'b0;
        send(4'd9, 16'hA5A5, 16'h0FF0, 8'h00, acc1);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 30) begin @(negedge clk); n++; end
        chk("bp_rsp_valid_seen", {31'd0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = (i == 2);
            bus.req_op = 4'd0; bus.req_a = 16'h7777; bus.req_b = 16'h1111;
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        // Back-to-back requests
        send(4'd2, 16'h1000, 16'h0234, 8'h00, acc1);
        send(4'd7, 16'hF0F0, 16'h3C3C, 8'h00, acc2);
        chk("b2b_spacing", acc2 - acc1, 32'd9);
        drain();

        // Reset during COMP
        send(4'd0, 16'h0101, 16'h0202, 8'h00, acc1);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.alu_com != 4'd7 && n < 20) begin @(negedge clk); n++; end
        chk("reached_comp", {28'd0, bus.alu_com}, 32'd7);
        reset = 1'b1;
        #1;
        chk("midrst_alu_com", {28'd0, bus.alu_com}, 32'd0);
        chk("midrst_bus_out", {16'd0, bus.alu_bus_out}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("postrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("postrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
        end
        send(4'd2, 16'h0005, 16'h0003, 8'h00, acc1);   // SUB 5-3
        drain();

        send(4'd5, 16'h00FF, 16'h4321, 8'h00, acc1);   // INC
        drain();
        send(4'd6, 16'h0000, 16'h1234, 8'h00, acc1);   // DEC
        drain();

        // Randomized traffic with random backpressure
        rand_ready = 1;
        for (int t = 0; t < 30; t++) begin
            send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom), acc1);
            if ($urandom_range(0, 1) == 1) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        rand_ready = 0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
